// File: rtl/boot_loader_if.sv
// Firmware stream and memory write port of the boot loader.
// master: stream source / memory observer; slave: the loader itself.
interface boot_loader_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/boot_loader.sv
// Pre-boot loader: streams firmware into memory at LOAD_BASE, writes the 6502
// reset vector, then holds the CPU in reset for HOLD_CYCLES before releasing it.
module boot_loader #(
    parameter int unsigned            ADDR_WIDTH  = 16,
    parameter int unsigned            DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]  LOAD_BASE   = 16'h8000,
    parameter logic [ADDR_WIDTH-1:0]  VECTOR_ADDR = 16'hFFFC,
    parameter int unsigned            MAX_LEN     = 4096,
    parameter int unsigned            HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [12:0]         len,
    input  logic                abort,
    boot_loader_if.slave        bus,
    output logic                cpu_reset_n,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int unsigned LEN_W  = 13;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VEC_LO,
        S_VEC_HI,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    count;
    logic [LEN_W-1:0]    len_q;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [ADDR_WIDTH:0] end_addr;
    logic                len_bad;
    logic                accept;

    // Image must fit below the vector and within MAX_LEN; sum kept one bit wider to avoid wrap.
    assign end_addr    = {1'b0, LOAD_BASE} + (ADDR_WIDTH + 1)'(len);
    assign len_bad     = (32'(len) > MAX_LEN) || (end_addr > {1'b0, VECTOR_ADDR});
    assign bus.s_ready = (state == S_LOAD);
    assign accept      = bus.s_valid && (state == S_LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            count        <= '0;
            len_q        <= '0;
            hold_cnt     <= '0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            cpu_reset_n  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_bad) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else if (len == '0) begin
                            state <= S_VEC_LO;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                            count <= '0;
                            len_q <= len;
                        end
                    end
                end
                S_LOAD: begin
                    // Abort wins over a same-cycle accept: that byte is dropped.
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= LOAD_BASE + ADDR_WIDTH'(count);
                        bus.mem_din  <= bus.s_data;
                        count        <= count + LEN_W'(1);
                        if (count == len_q - LEN_W'(1)) begin
                            state <= S_VEC_LO;
                        end
                    end
                end
                S_VEC_LO: begin
                    bus.mem_we   <= 1'b1;
                    bus.mem_addr <= VECTOR_ADDR;
                    bus.mem_din  <= LOAD_BASE[7:0];
                    state        <= S_VEC_HI;
                end
                S_VEC_HI: begin
                    bus.mem_we   <= 1'b1;
                    bus.mem_addr <= VECTOR_ADDR + ADDR_WIDTH'(1);
                    bus.mem_din  <= LOAD_BASE[15:8];
                    hold_cnt     <= '0;
                    state        <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state       <= S_RUN;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        cpu_reset_n <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
